// File: rtl/fifo72_arb2.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// fifo72_arb2
//
// Two-input frame arbiter between first-word-fall-through FIFOs carrying
// 72-bit words (8 lanes of {ctrl bit, byte}). Whole frames are forwarded from
// one input at a time to a single downstream FIFO write port. Frames that grow
// past MAX_WORDS are cut short with a forced terminator, and the rest of the
// frame is dropped.
//
// Handshake:
//   * Upstream: a word leaves input N in any cycle where inN_rd_en = 1.
//     inN_rd_en is only raised while inN_empty = 0, so a strobe always pops a
//     real word, and the pop completes in that same cycle.
//   * Downstream: out_wr_en = 1 writes out_din in that cycle. out_full is a
//     programmable-full flag with at least 2 words of slack, so it is sampled
//     as a "do not start a new write" signal; the registered write strobe
//     never depends on out_full combinationally.
//
// Ports:
//   sys_clk, sys_rst_n     clock; asynchronous active-low reset
//   in0_dout, in1_dout     FIFO head words, [71:64] ctrl, [63:0] lane bytes
//   in0_empty, in1_empty   FIFO empty flags
//   in0_rd_en, in1_rd_en   pop strobes (combinational)
//   out_full               downstream almost-full
//   out_wr_en, out_din     registered write strobe and word
//   grant                  index of the current or most recent owner
//   trunc_cnt              number of truncated frames (wraps)
//   junk_cnt               number of discarded non-idle words in IDLE (wraps)
//   dbg_state              FSM state: 0 IDLE, 1 XFER, 2 DROP
// ----------------------------------------------------------------------------
module fifo72_arb2 #(
  parameter int MAX_WORDS = 1200
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [71:0] in0_dout,
  input  logic [71:0] in1_dout,
  input  logic        in0_empty,
  input  logic        in1_empty,
  output logic        in0_rd_en,
  output logic        in1_rd_en,
  input  logic        out_full,
  output logic        out_wr_en,
  output logic [71:0] out_din,
  output logic        grant,
  output logic [15:0] trunc_cnt,
  output logic [15:0] junk_cnt,
  output logic [1:0]  dbg_state
);

  localparam logic [71:0] IDLE_WORD = 72'hFF_0707070707070707;
  localparam logic [71:0] TERM_WORD = 72'hFF_07070707070707FD;
  localparam logic [13:0] MAX_W     = 14'(MAX_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // Word classification helpers.
  function automatic logic is_sof(input logic [71:0] w);
    return w[64] && (w[7:0] == 8'hFB);
  endfunction

  function automatic logic is_eof(input logic [71:0] w);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (w[64+k] && (w[8*k +: 8] == 8'hFD)) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic is_idle(input logic [71:0] w);
    return w == IDLE_WORD;
  endfunction

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic [13:0] cnt_q, cnt_d;
  logic [15:0] trunc_q, trunc_d;
  logic [15:0] junk_q, junk_d;
  logic        wr_q, wr_d;
  logic [71:0] din_q, din_d;

  // Combinational pop decisions before reset gating.
  logic        pop0, pop1;
  logic [1:0]  junk_inc;

  // Per-input classification of the current heads.
  logic        sof0, sof1;
  logic        idle0, idle1;
  logic [71:0] g_head;
  logic        g_empty;
  logic        g_eof;

  assign sof0  = !in0_empty && is_sof(in0_dout);
  assign sof1  = !in1_empty && is_sof(in1_dout);
  assign idle0 = is_idle(in0_dout);
  assign idle1 = is_idle(in1_dout);

  // Head of the granted input, used in XFER and DROP.
  assign g_head  = grant_q ? in1_dout  : in0_dout;
  assign g_empty = grant_q ? in1_empty : in0_empty;
  assign g_eof   = is_eof(g_head);

  always_comb begin
    pop0     = 1'b0;
    pop1     = 1'b0;
    junk_inc = 2'd0;
    state_d  = state_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    trunc_d  = trunc_q;
    wr_d     = 1'b0;
    din_d    = din_q;

    case (state_q)
      ST_IDLE: begin
        if (sof0 && sof1) begin
          // Tie: the input that did not own the link most recently wins.
          grant_d = ~grant_q;
          state_d = ST_XFER;
          cnt_d   = '0;
        end else if (sof0) begin
          grant_d = 1'b0;
          state_d = ST_XFER;
          cnt_d   = '0;
          pop1    = !in1_empty;
        end else if (sof1) begin
          grant_d = 1'b1;
          state_d = ST_XFER;
          cnt_d   = '0;
          pop0    = !in0_empty;
        end else begin
          pop0 = !in0_empty;
          pop1 = !in1_empty;
        end
        // The granted SOF is never popped here, so any pop is a discard.
        junk_inc = {1'b0, pop0 && !idle0} + {1'b0, pop1 && !idle1};
      end

      ST_XFER: begin
        if (!out_full) begin
          if (cnt_q == MAX_W) begin
            // Frame too long: close it downstream and drop the remainder.
            wr_d    = 1'b1;
            din_d   = TERM_WORD;
            trunc_d = trunc_q + 16'd1;
            state_d = ST_DROP;
          end else if (!g_empty) begin
            pop0  = ~grant_q;
            pop1  = grant_q;
            wr_d  = 1'b1;
            din_d = g_head;
            cnt_d = cnt_q + 14'd1;
            if (g_eof) state_d = ST_IDLE;
          end
        end
      end

      ST_DROP: begin
        // Draining ignores out_full because nothing is written.
        if (!g_empty) begin
          pop0 = ~grant_q;
          pop1 = grant_q;
          if (g_eof) state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    junk_d = junk_q + 16'(junk_inc);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b1;
      cnt_q   <= '0;
      trunc_q <= '0;
      junk_q  <= '0;
      wr_q    <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
      junk_q  <= junk_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
    end
  end

  // Pops are combinational, so they are gated directly by reset to stay
  // quiet while the block is held in reset.
  assign in0_rd_en = pop0 && sys_rst_n;
  assign in1_rd_en = pop1 && sys_rst_n;

  assign out_wr_en = wr_q;
  assign out_din   = din_q;
  assign grant     = grant_q;
  assign trunc_cnt = trunc_q;
  assign junk_cnt  = junk_q;
  assign dbg_state = state_q;

endmodule
